// File: rtl/mod977_vec_accum.sv
// Modular vector accumulator: sums each run of LEN residues mod Q and emits one
// reduced sum per vector. Optional input range check: MOD977_ACC_RANGE_CHECK_EN.
module mod977_vec_accum #(
  parameter int Q   = 977,
  parameter int W   = 10,
  parameter int LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         err
);

  localparam int            CW       = $clog2(LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
  localparam logic [W:0]    Q_WIDE   = (W + 1)'(Q);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t        state_q;
  logic [W-1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [W:0]    x_w;
  logic [W:0]    sum_w;
  logic [W:0]    sum_red;
  logic [W-1:0]  acc_d;
  logic          x_oor;

  // Single conditional-subtract modular add of the (optionally pre-corrected) input.
  always_comb begin
    x_w   = {1'b0, in_data};
    x_oor = (x_w >= Q_WIDE);
`ifdef MOD977_ACC_RANGE_CHECK_EN
    if (x_oor) begin
      x_w = x_w - Q_WIDE;
    end else begin
      x_w = {1'b0, in_data};
    end
`endif
    sum_w = {1'b0, acc_q} + x_w;
    if (sum_w >= Q_WIDE) begin
      sum_red = sum_w - Q_WIDE;
    end else begin
      sum_red = sum_w;
    end
    acc_d = sum_red[W-1:0];
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef MOD977_ACC_RANGE_CHECK_EN
  logic err_q;
  assign err = err_q;

  // Sticky flag for any accepted out-of-range residue; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (!clr && in_valid && (state_q == ACCUM) && x_oor) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Accumulate/hold state machine; clr drops any partial vector or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clr) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (cnt_q == CNT_LAST) begin
              out_data_q  <= acc_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              state_q     <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q     <= ACCUM;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod977_vec_accum.sv
// Directed self-checking bench for mod977_vec_accum with LEN=4.
module tb_mod977_vec_accum;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst, clr, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, err;
  logic [W-1:0] out_data;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  mod977_vec_accum #(.Q(977), .W(W), .LEN(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer x until accepted (bounded), then idle for gap cycles.
  task automatic feed(input int x, input int gap);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = W'(x);
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check_eq("in_ready_wait", int'(waited < 20), 1);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_out(input string tag, input int exp);
    check_eq({tag, "_valid"}, int'(out_valid), 1);
    check_eq({tag, "_data"}, int'(out_data), exp);
    check_eq({tag, "_in_ready"}, int'(in_ready), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    tick();
    do_reset();
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_data", int'(out_data), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_acc", int'(dut.acc_q), 0);

    // 500 x4 back-to-back: 500, 23, 523 -> 46
    feed(500, 0); check_eq("v500_acc1", int'(dut.acc_q), 500);
    feed(500, 0); check_eq("v500_acc2", int'(dut.acc_q), 23);
    feed(500, 0); check_eq("v500_acc3", int'(dut.acc_q), 523);
    feed(500, 0); check_out("v500", 46);
    tick();
    check_eq("v500_drop_valid", int'(out_valid), 0);
    check_eq("v500_ready_back", int'(in_ready), 1);

    // 976 x4: 976, 975, 974 -> 973
    feed(976, 0); check_eq("v976_acc1", int'(dut.acc_q), 976);
    feed(976, 0); check_eq("v976_acc2", int'(dut.acc_q), 975);
    feed(976, 0); check_eq("v976_acc3", int'(dut.acc_q), 974);
    feed(976, 0); check_out("v976", 973);
    tick();

    for (int i = 0; i < 4; i++) feed(0, 0);
    check_out("vzero", 0);
    tick();

    // Backpressure with 1,2,3,4 -> 10 held for 5 cycles
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) feed(i, 0);
    check_out("bp", 10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("bp_hold", 10);
    end
    out_ready = 1'b1;
    tick();
    check_eq("bp_release_valid", int'(out_valid), 0);
    check_eq("bp_release_ready", int'(in_ready), 1);

    // in_valid gaps: 100,200,300,400 -> 23
    feed(100, 3); check_eq("gap_acc1", int'(dut.acc_q), 100);
    check_eq("gap_cnt1", int'(dut.cnt_q), 1);
    feed(200, 3); check_eq("gap_acc2", int'(dut.acc_q), 300);
    feed(300, 3); check_eq("gap_acc3", int'(dut.acc_q), 600);
    check_eq("gap_cnt3", int'(dut.cnt_q), 3);
    feed(400, 0); check_out("gap", 23);
    tick();

    // clr after two accepts, with a same-cycle input that must be ignored
    feed(976, 0);
    feed(5, 0);
    check_eq("clr_pre_acc", int'(dut.acc_q), 4);
    clr = 1'b1; in_valid = 1'b1; in_data = W'(7);
    tick();
    clr = 1'b0; in_valid = 1'b0;
    check_eq("clr_acc", int'(dut.acc_q), 0);
    check_eq("clr_cnt", int'(dut.cnt_q), 0);
    for (int i = 0; i < 4; i++) feed(1, 0);
    check_out("clr_vec", 4);
    tick();

    // clr during HOLD discards the pending result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(2, 0);
    check_out("hold_vec", 8);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("hold_clr_valid", int'(out_valid), 0);
    check_eq("hold_clr_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    tick();
    check_eq("hold_clr_no_out", int'(out_valid), 0);

`ifdef MOD977_ACC_RANGE_CHECK_EN
    feed(1000, 0); feed(0, 0); feed(0, 0); feed(0, 0);
    check_out("rng", 23);
    check_eq("rng_err_set", int'(err), 1);
    tick();
    for (int i = 0; i < 4; i++) feed(3, 0);
    check_out("rng_next", 12);
    check_eq("rng_err_sticky", int'(err), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("rng_err_after_clr", int'(err), 1);
    do_reset();
    check_eq("rng_err_after_rst", int'(err), 0);
`else
    check_eq("err_tied_low", int'(err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mod977_vec_accum.md
Name: mod977_vec_accum

Overview:
- Downstream consumer of the mod-977 Barrett reduction stage.
- Takes a stream of reduced residues (10-bit, < 977) over a valid/ready handshake and sums each fixed-length vector of LEN residues modulo 977.
- Emits one reduced sum per vector on a registered output handshake.
- Used as the accumulation stage for dot products and polynomial coefficient sums.

Parameters:
- Q, 977, modulus; must satisfy Q < 2^W.
- W, 10, residue width in bits.
- LEN, 16, residues per vector; must be ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous abort of the current vector; active-high.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept in_data.
- in_data  in  W  residue input, expected < Q.
- out_valid  out  1  out_data holds a completed vector sum.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  W  vector sum mod Q.
- err  out  1  sticky out-of-range flag; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=ACCUM, acc=0, cnt=0.
  - out_valid=0, out_data=0, err=0.
  - Priority: rst > clr > normal operation.
- Modular add:
  - s = acc + x, computed at W+1 bits.
  - r = (s ≥ Q) ? s−Q : s.
  - Exactly one conditional subtract; no multiplier.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Transfer occurs when in_valid && in_ready.
  - On a transfer with cnt < LEN−1: acc ← r, cnt ← cnt+1.
  - On a transfer with cnt == LEN−1:
    - out_data ← r, out_valid ← 1.
    - acc ← 0, cnt ← 0.
    - Go to HOLD.
  - No transfer: acc and cnt hold.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_data is stable until accepted.
  - When out_ready=1: out_valid ← 0, go to ACCUM.
  - in_ready stays 0 in the acceptance cycle; the next input is taken from the following cycle.
- Latency and throughput:
  - The last element accepted at edge t gives out_valid=1 after edge t.
  - Minimum cadence is LEN+1 cycles per vector.
- clr=1 at an edge:
  - acc=0, cnt=0, out_valid=0, state=ACCUM.
  - Any pending output is discarded.
  - An input transfer in the same cycle is ignored.
  - err is not cleared by clr.
- Counter: cnt width is clog2(LEN); it wraps to 0 only via vector completion, clr or rst.
- in_ready is a function of state only; it has no combinational path from in_valid or out_ready.

Optional Feature:
- Macro name: MOD977_ACC_RANGE_CHECK_EN.
- When defined:
  - An input x ≥ Q is pre-corrected to x−Q before the modular add. This is valid for all W-bit x, since 2^W−1 < 2Q.
  - err ← 1 on any accepted x ≥ Q.
  - err is cleared only by rst.
- When undefined:
  - No pre-correction is applied and err is tied 0.
  - Inputs ≥ Q give an undefined sum; the result is not guaranteed < Q.

Test Plan (LEN=4):
- Reset, then inputs 500,500,500,500 back-to-back with out_ready=1 → intermediate acc 500, 23, 523. out_valid one cycle after the 4th accept with out_data=46; in_ready=0 for exactly one cycle.
- Inputs 976×4 → out_data=973 (acc sequence 976, 975, 974). Inputs 0×4 → out_data=0.
- Backpressure: complete a vector of 1,2,3,4, then hold out_ready=0 for 5 cycles → out_valid=1 with out_data=10 stable and in_ready=0 throughout. out_ready=1 → out_valid=0 next cycle, in_ready=1.
- Gaps on in_valid: inputs 100,200,300,400 with 3 idle cycles between each → out_data=1000−977=23; cnt and acc are unchanged during the gaps.
- clr after 2 accepts (977−1, 5), then inputs 1,1,1,1 → out_data=4. clr asserted during HOLD → out_valid drops the next cycle and no output is delivered.
- With MOD977_ACC_RANGE_CHECK_EN defined: inputs 1000,0,0,0 → out_data=23 and err=1. err stays 1 across later vectors and a clr, and clears only on rst.
